// File: rtl/k64_spi_slave.sv
// SPI slave endpoint for the K64 SPI master (mode 0, MSB first).
// The SPI pins are oversampled in the clk domain. Each frame holds a command
// byte (R/W + address) and one data word. A frame produces either a one-cycle
// register write strobe, or a read request whose data is returned on MISO in
// the same frame.
module k64_spi_slave #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 7,
  localparam int FRAME_W = 1 + ADDR_W + DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              k64_spi_cs,
  input  logic              k64_spi_clk,
  input  logic              k64_spi_din,
  output logic              k64_spi_dout,
  output logic              k64_spi_dout_oe,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              frame_err,
  output logic              busy
);

  localparam int CNT_W = $clog2(FRAME_W + 2);
  localparam logic [CNT_W-1:0] CNT_CMD   = CNT_W'(1 + ADDR_W);
  localparam logic [CNT_W-1:0] CNT_FRAME = CNT_W'(FRAME_W);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(FRAME_W + 1);

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    DATA,
    DONE
  } state_t;

  // Synchronizer chains. The third cs/sclk stage exists only for edge detection.
  logic [2:0] csSync_q;
  logic [2:0] sclkSync_q;
  logic [1:0] mosiSync_q;

  logic csRise, csFall, sclkRise, sclkFall, mosiBit;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       bitCnt_q, bitCnt_d;
  logic [FRAME_W-3:0]     rx_q, rx_d;
  logic [DATA_W-1:0]      tx_q, tx_d;
  logic                   isRead_q, isRead_d;
  logic                   overrun_q, overrun_d;
  logic                   loadNow_q, loadNow_d;
  logic                   wrEn_q, wrEn_d;
  logic [ADDR_W-1:0]      wrAddr_q, wrAddr_d;
  logic [DATA_W-1:0]      wrData_q, wrData_d;
  logic                   rdEn_q, rdEn_d;
  logic [ADDR_W-1:0]      rdAddr_q, rdAddr_d;
  logic                   frameErr_q, frameErr_d;

  logic [FRAME_W-2:0]     rxNext;
  logic [CNT_W-1:0]       bitCntInc;

  // Bring the asynchronous SPI pins into the clk domain. CS resets low so that
  // a CS already low at reset release is not mistaken for a frame start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csSync_q   <= '0;
      sclkSync_q <= '0;
      mosiSync_q <= '0;
    end else begin
      csSync_q   <= {csSync_q[1:0], k64_spi_cs};
      sclkSync_q <= {sclkSync_q[1:0], k64_spi_clk};
      mosiSync_q <= {mosiSync_q[0], k64_spi_din};
    end
  end

  assign csRise   =  csSync_q[1]   & ~csSync_q[2];
  assign csFall   = ~csSync_q[1]   &  csSync_q[2];
  assign sclkRise =  sclkSync_q[1] & ~sclkSync_q[2];
  assign sclkFall = ~sclkSync_q[1] &  sclkSync_q[2];
  assign mosiBit  =  mosiSync_q[1];

  assign rxNext    = {rx_q, mosiBit};
  assign bitCntInc = (bitCnt_q == CNT_MAX) ? bitCnt_q : bitCnt_q + CNT_W'(1);

  // Frame decoder state register and all datapath/output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      bitCnt_q   <= '0;
      rx_q       <= '0;
      tx_q       <= '0;
      isRead_q   <= 1'b0;
      overrun_q  <= 1'b0;
      loadNow_q  <= 1'b0;
      wrEn_q     <= 1'b0;
      wrAddr_q   <= '0;
      wrData_q   <= '0;
      rdEn_q     <= 1'b0;
      rdAddr_q   <= '0;
      frameErr_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bitCnt_q   <= bitCnt_d;
      rx_q       <= rx_d;
      tx_q       <= tx_d;
      isRead_q   <= isRead_d;
      overrun_q  <= overrun_d;
      loadNow_q  <= loadNow_d;
      wrEn_q     <= wrEn_d;
      wrAddr_q   <= wrAddr_d;
      wrData_q   <= wrData_d;
      rdEn_q     <= rdEn_d;
      rdAddr_q   <= rdAddr_d;
      frameErr_q <= frameErr_d;
    end
  end

  // Next-state logic: CS rise aborts/ends any frame. Otherwise the current state
  // handles the detected SCLK edges. The tx word is captured the cycle after
  // rd_en, because the register file answers one clk after the request.
  always_comb begin
    state_d    = state_q;
    bitCnt_d   = bitCnt_q;
    rx_d       = rx_q;
    tx_d       = tx_q;
    isRead_d   = isRead_q;
    overrun_d  = overrun_q;
    loadNow_d  = rdEn_q;
    wrEn_d     = 1'b0;
    wrAddr_d   = wrAddr_q;
    wrData_d   = wrData_q;
    rdEn_d     = 1'b0;
    rdAddr_d   = rdAddr_q;
    frameErr_d = 1'b0;

    if (csRise) begin
      state_d   = IDLE;
      bitCnt_d  = '0;
      isRead_d  = 1'b0;
      overrun_d = 1'b0;
      if (state_q != IDLE && (bitCnt_q < CNT_FRAME || overrun_q)) begin
        frameErr_d = 1'b1;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (csFall) begin
            state_d   = CMD;
            bitCnt_d  = '0;
            rx_d      = '0;
            tx_d      = '0;
            isRead_d  = 1'b0;
            overrun_d = 1'b0;
          end
        end
        CMD: begin
          if (sclkRise) begin
            bitCnt_d = bitCntInc;
            rx_d     = rxNext[FRAME_W-3:0];
            if (bitCntInc == CNT_CMD) begin
              state_d = DATA;
              if (rxNext[ADDR_W]) begin
                isRead_d = 1'b1;
                rdEn_d   = 1'b1;
                rdAddr_d = rxNext[ADDR_W-1:0];
              end
            end
          end
        end
        DATA: begin
          if (loadNow_q && isRead_q) begin
            tx_d = rd_data;
          end else if (sclkFall && isRead_q && bitCnt_q > CNT_CMD) begin
            tx_d = {tx_q[DATA_W-2:0], 1'b0};
          end
          if (sclkRise) begin
            bitCnt_d = bitCntInc;
            rx_d     = rxNext[FRAME_W-3:0];
            if (bitCntInc == CNT_FRAME) begin
              state_d = DONE;
              if (!isRead_q) begin
                wrEn_d   = 1'b1;
                wrAddr_d = rxNext[DATA_W+ADDR_W-1:DATA_W];
                wrData_d = rxNext[DATA_W-1:0];
              end
            end
          end
        end
        DONE: begin
          if (sclkRise) begin
            overrun_d = 1'b1;
            bitCnt_d  = bitCntInc;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign busy            = (state_q != IDLE);
  assign k64_spi_dout_oe = busy;
  assign k64_spi_dout    = isRead_q & ~overrun_q & tx_q[DATA_W-1];
  assign wr_en           = wrEn_q;
  assign wr_addr         = wrAddr_q;
  assign wr_data         = wrData_q;
  assign rd_en           = rdEn_q;
  assign rd_addr         = rdAddr_q;
  assign frame_err       = frameErr_q;

endmodule
